// File: rtl/register_file.sv
// Architectural register file with a pending-write scoreboard. Reads are registered (1 cycle).
// Busy flags are combinational. Defining REGFILE_BYPASS_EN adds same-cycle write-to-read forwarding.
module register_file #(
   parameter int DATA_W   = 64,
   parameter int ADDR_W   = 5,
   parameter int ZERO_REG = 31
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] ReadReg1,
   input  logic [ADDR_W-1:0] ReadReg2,
   input  logic              ReadEn,
   output logic [DATA_W-1:0] ReadData1,
   output logic [DATA_W-1:0] ReadData2,
   input  logic [ADDR_W-1:0] Reg2Write,
   input  logic [DATA_W-1:0] Data2Write,
   input  logic              RegWrite,
   input  logic              SetBusy,
   input  logic [ADDR_W-1:0] BusyReg,
   output logic              Busy1,
   output logic              Busy2
);

   localparam int               DEPTH = 1 << ADDR_W;
   localparam logic [ADDR_W-1:0] ZR   = ADDR_W'(ZERO_REG);

   logic [DATA_W-1:0] r_regs [DEPTH];
   logic [DEPTH-1:0]  r_busy;

   logic              w_wr_en;
   logic              w_set_en;
   logic [DATA_W-1:0] w_val1;
   logic [DATA_W-1:0] w_val2;
   logic [DEPTH-1:0]  w_busy_nxt;

   assign w_wr_en  = RegWrite && (Reg2Write != ZR);
   assign w_set_en = SetBusy && (BusyReg != ZR);

`ifdef REGFILE_BYPASS_EN
   logic w_wb_hit1;
   logic w_wb_hit2;

   assign w_wb_hit1 = RegWrite && (Reg2Write == ReadReg1);
   assign w_wb_hit2 = RegWrite && (Reg2Write == ReadReg2);

   // Write-back landing this cycle satisfies the dependency, so decode need not wait for it.
   assign Busy1 = r_busy[ReadReg1] & ~w_wb_hit1;
   assign Busy2 = r_busy[ReadReg2] & ~w_wb_hit2;
`else
   assign Busy1 = r_busy[ReadReg1];
   assign Busy2 = r_busy[ReadReg2];
`endif

   always_comb begin
      w_val1 = r_regs[ReadReg1];
      w_val2 = r_regs[ReadReg2];
      if (ReadReg1 == ZR) begin
         w_val1 = '0;
      end
`ifdef REGFILE_BYPASS_EN
      else if (w_wr_en && w_wb_hit1) begin
         w_val1 = Data2Write;
      end
`endif
      if (ReadReg2 == ZR) begin
         w_val2 = '0;
      end
`ifdef REGFILE_BYPASS_EN
      else if (w_wr_en && w_wb_hit2) begin
         w_val2 = Data2Write;
      end
`endif
   end

   // Set is applied after clear: a newly issued writer outranks the one retiring now.
   always_comb begin
      w_busy_nxt = r_busy;
      if (RegWrite) begin
         w_busy_nxt[Reg2Write] = 1'b0;
      end
      if (w_set_en) begin
         w_busy_nxt[BusyReg] = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_regs[i] <= '0;
         end
         r_busy    <= '0;
         ReadData1 <= '0;
         ReadData2 <= '0;
      end else begin
         if (w_wr_en) begin
            r_regs[Reg2Write] <= Data2Write;
         end
         r_busy <= w_busy_nxt;
         if (ReadEn) begin
            ReadData1 <= w_val1;
            ReadData2 <= w_val2;
         end
      end
   end

endmodule

// File: tb/tb_register_file.sv
// Scoreboard bench for register_file: stimulus pushes per-cycle expectations, a monitor checks them.
module tb_register_file;

`ifdef REGFILE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [4:0]  ReadReg1 = '0, ReadReg2 = '0, Reg2Write = '0, BusyReg = '0;
   logic        ReadEn = 1'b0, RegWrite = 1'b0, SetBusy = 1'b0;
   logic [63:0] Data2Write = '0;
   logic [63:0] ReadData1, ReadData2;
   logic        Busy1, Busy2;

   register_file dut (
      .clk(clk), .rst_n(rst_n),
      .ReadReg1(ReadReg1), .ReadReg2(ReadReg2), .ReadEn(ReadEn),
      .ReadData1(ReadData1), .ReadData2(ReadData2),
      .Reg2Write(Reg2Write), .Data2Write(Data2Write), .RegWrite(RegWrite),
      .SetBusy(SetBusy), .BusyReg(BusyReg),
      .Busy1(Busy1), .Busy2(Busy2)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        chk_rd;
      logic [63:0] d1;
      logic [63:0] d2;
      logic        chk_bz;
      logic        b1;
      logic        b2;
      logic [15:0] id;
   } exp_t;

   exp_t exp_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   cyc_id  = 0;

   logic        pend_rd = 1'b1;
   logic [63:0] pend_d1 = '0;
   logic [63:0] pend_d2 = '0;

   localparam logic [63:0] DB = 64'hDEAD_BEEF_0123_4567;

   task automatic chk(input string nm, input int id, input logic [63:0] act, input logic [63:0] expv);
      n_tests++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s cyc%0d: got %h expected %h", nm, id, act, expv);
      end
   endtask

   // Monitor: one expectation record per cycle, checked mid-cycle.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (e.chk_rd) begin
               chk("ReadData1", int'(e.id), ReadData1, e.d1);
               chk("ReadData2", int'(e.id), ReadData2, e.d2);
            end
            if (e.chk_bz) begin
               chk("Busy1", int'(e.id), {63'd0, Busy1}, {63'd0, e.b1});
               chk("Busy2", int'(e.id), {63'd0, Busy2}, {63'd0, e.b2});
            end
         end
      end
   end

   // Drives one cycle. Busy expectation applies to this cycle's inputs; read expectation
   // (cr/ed1/ed2) applies to the data captured at the next edge and is checked one cycle later.
   task automatic cyc(input logic re, input logic [4:0] r1, input logic [4:0] r2,
                      input logic we, input logic [4:0] wa, input logic [63:0] wd,
                      input logic sb, input logic [4:0] ba,
                      input logic cb, input logic eb1, input logic eb2,
                      input logic cr, input logic [63:0] ed1, input logic [63:0] ed2);
      exp_t e;
      @(posedge clk);
      #1;
      cyc_id++;
      e.chk_rd = pend_rd; e.d1 = pend_d1; e.d2 = pend_d2;
      e.chk_bz = cb; e.b1 = eb1; e.b2 = eb2; e.id = 16'(cyc_id);
      exp_q.push_back(e);
      ReadEn = re; ReadReg1 = r1; ReadReg2 = r2;
      RegWrite = we; Reg2Write = wa; Data2Write = wd;
      SetBusy = sb; BusyReg = ba;
      pend_rd = cr; pend_d1 = ed1; pend_d2 = ed2;
   endtask

   initial begin
      exp_t e;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      //  re  r1  r2  we  wa  wd           sb  ba  cb b1 b2  cr  ed1          ed2
      cyc(0, 0,  0,  0,  0,  64'h0,       0,  0,  1, 0, 0,  0,  64'h0,       64'h0);
      cyc(0, 0,  0,  1,  5,  DB,          0,  0,  1, 0, 0,  0,  64'h0,       64'h0);
      cyc(1, 5,  0,  0,  0,  64'h0,       0,  0,  1, 0, 0,  1,  DB,          64'h0);
      cyc(0, 5,  0,  0,  0,  64'h0,       0,  0,  1, 0, 0,  1,  DB,          64'h0);
      cyc(1, 31, 31, 1,  31, '1,          1,  31, 1, 0, 0,  1,  64'h0,       64'h0);
      cyc(1, 31, 31, 0,  0,  64'h0,       0,  0,  1, 0, 0,  1,  64'h0,       64'h0);
      cyc(0, 0,  0,  1,  7,  64'h11,      0,  0,  1, 0, 0,  0,  64'h0,       64'h0);
      cyc(1, 7,  7,  1,  7,  64'h22,      0,  0,  1, 0, 0,  1,
          BYP ? 64'h22 : 64'h11, BYP ? 64'h22 : 64'h11);
      cyc(1, 7,  7,  0,  0,  64'h0,       0,  0,  1, 0, 0,  1,  64'h22,      64'h22);
      cyc(0, 9,  0,  0,  0,  64'h0,       1,  9,  1, 0, 0,  0,  64'h0,       64'h0);
      cyc(0, 9,  0,  0,  0,  64'h0,       0,  0,  1, 1, 0,  0,  64'h0,       64'h0);
      cyc(0, 9,  0,  0,  0,  64'h0,       0,  0,  1, 1, 0,  0,  64'h0,       64'h0);
      cyc(1, 9,  0,  1,  9,  64'h99,      0,  0,  1, !BYP, 0, 1,
          BYP ? 64'h99 : 64'h0, 64'h0);
      cyc(0, 9,  0,  0,  0,  64'h0,       0,  0,  1, 0, 0,  0,  64'h0,       64'h0);
      cyc(0, 3,  9,  0,  0,  64'h0,       1,  3,  1, 0, 0,  0,  64'h0,       64'h0);
      cyc(0, 3,  0,  1,  3,  64'h33,      1,  3,  1, !BYP, 0, 0, 64'h0,       64'h0);
      cyc(0, 3,  0,  0,  0,  64'h0,       0,  0,  1, 1, 0,  0,  64'h0,       64'h0);
      cyc(0, 3,  0,  1,  3,  64'h34,      0,  0,  1, !BYP, 0, 0, 64'h0,       64'h0);
      cyc(1, 3,  5,  0,  0,  64'h0,       0,  0,  1, 0, 0,  1,  64'h34,      DB);
      cyc(0, 0,  0,  0,  0,  64'h0,       1,  12, 1, 0, 0,  0,  64'h0,       64'h0);
      cyc(1, 12, 12, 0,  0,  64'h0,       0,  0,  1, 1, 1,  1,  64'h0,       64'h0);
      cyc(1, 5,  7,  0,  0,  64'h0,       0,  0,  1, 0, 0,  1,  DB,          64'h22);
      cyc(0, 12, 12, 0,  0,  64'h0,       0,  0,  1, 1, 1,  0,  64'h0,       64'h0);

      // Asynchronous reset mid-cycle: outputs must clear before the next edge.
      @(posedge clk);
      #1;
      cyc_id++;
      e.chk_rd = 1'b1; e.d1 = '0; e.d2 = '0;
      e.chk_bz = 1'b1; e.b1 = 1'b0; e.b2 = 1'b0; e.id = 16'(cyc_id);
      exp_q.push_back(e);
      #1;
      rst_n = 1'b0;
      ReadEn = 1'b0; RegWrite = 1'b0; SetBusy = 1'b0;
      pend_rd = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      for (int i = 0; i < 16; i++) begin
         cyc(1, 5'(2*i), 5'(2*i+1), 0, 0, 64'h0, 0, 0, 1, 0, 0, 1, 64'h0, 64'h0);
      end
      cyc(0, 0, 0, 0, 0, 64'h0, 0, 0, 1, 0, 0, 0, 64'h0, 64'h0);

      for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
      if (exp_q.size() > 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
      end
      @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
